fetch_seq_ctrl: RTL and testbench

FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

---
 rtl/fetch_seq_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// Instruction fetch sequencer: reads an instruction one byte at a time, sizes it
// from the icode of byte 0, then holds it for the decoder until accepted.
module fetch_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] start_pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_error,
    output logic [79:0] ibytes,
    output logic        ibytes_valid,
    input  logic        ibytes_ready,
    output logic        imem_error,
    output logic [63:0] cur_pc,
    input  logic        next_pc_valid,
    input  logic [63:0] next_pc,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRESENT,
        WAIT_PC,
        HALT
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [3:0]  r_cnt;
    logic [79:0] r_ibytes;
    logic        r_imemErr;

    logic [3:0]  w_icode;
    logic [3:0]  w_len;
    logic [3:0]  w_cntNext;
    logic        w_haltOnAccept;

    function automatic logic [3:0] instrLen(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:             instrLen = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:       instrLen = 4'd2;
            4'h7, 4'h8:                   instrLen = 4'd9;
            4'h3, 4'h4, 4'h5, 4'hC:       instrLen = 4'd10;
            default:                      instrLen = 4'd1;
        endcase
    endfunction

    // On the very first ack byte 0 is not yet in r_ibytes, so size from the bus.
    assign w_icode        = (r_cnt == 4'd0) ? mem_rdata[7:4] : r_ibytes[7:4];
    assign w_len          = instrLen(w_icode);
    assign w_cntNext      = r_cnt + 4'd1;
    assign w_haltOnAccept = r_imemErr || (r_ibytes[7:4] == 4'h0) || (r_ibytes[7:4] >= 4'hD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= 64'd0;
            r_cnt     <= 4'd0;
            r_ibytes  <= 80'd0;
            r_imemErr <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        r_pc      <= start_pc;
                        r_cnt     <= 4'd0;
                        r_ibytes  <= 80'd0;
                        r_imemErr <= 1'b0;
                        r_state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        if (mem_error) begin
                            r_imemErr <= 1'b1;
                            r_state   <= PRESENT;
                        end else begin
                            r_ibytes[{r_cnt, 3'b000} +: 8] <= mem_rdata;
                            r_cnt <= w_cntNext;
                            if (w_cntNext >= w_len) begin
                                r_state <= PRESENT;
                            end
                        end
                    end
                end
                PRESENT: begin
                    if (ibytes_ready) begin
                        r_state <= w_haltOnAccept ? HALT : WAIT_PC;
                    end
                end
                WAIT_PC: begin
                    if (next_pc_valid) begin
                        r_pc     <= next_pc;
                        r_cnt    <= 4'd0;
                        r_ibytes <= 80'd0;
                        r_state  <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outside FETCH the address parks at pc so it never runs past pc+9.
    assign mem_req      = (r_state == FETCH);
    assign mem_addr     = r_pc + (mem_req ? {60'd0, r_cnt} : 64'd0);
    assign ibytes       = r_ibytes;
    assign ibytes_valid = (r_state == PRESENT);
    assign imem_error   = r_imemErr;
    assign cur_pc       = r_pc;
    assign busy         = (r_state != IDLE) && (r_state != HALT);
    assign halted       = (r_state == HALT);

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: a byte memory with random ack latency and fault
// injection, checked against an instruction-level model of each fetch.
module tb_fetch_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] start_pc;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_error;
    logic [79:0] ibytes;
    logic        ibytes_valid;
    logic        ibytes_ready;
    logic        imem_error;
    logic [63:0] cur_pc;
    logic        next_pc_valid;
    logic [63:0] next_pc;
    logic        busy;
    logic        halted;

    int testsRun = 0;
    int testsFailed = 0;

    bit [7:0]    mem [bit [63:0]];
    bit          errEn;
    bit [63:0]   errAt;
    logic [63:0] readQ [$];
    bit          timedOut;

    fetch_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_error(mem_error),
        .ibytes(ibytes), .ibytes_valid(ibytes_valid), .ibytes_ready(ibytes_ready),
        .imem_error(imem_error), .cur_pc(cur_pc),
        .next_pc_valid(next_pc_valid), .next_pc(next_pc),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic bit [7:0] memByte(input bit [63:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic int instrLen(input bit [3:0] ic);
        if (ic inside {4'h2, 4'h6, 4'hA, 4'hB}) return 2;
        if (ic inside {4'h7, 4'h8}) return 9;
        if (ic inside {4'h3, 4'h4, 4'h5, 4'hC}) return 10;
        return 1;
    endfunction

    // Instruction-level model: what one fetch starting at pc should produce.
    task automatic modelFetch(input bit [63:0] pc, output bit [79:0] eBytes,
                              output bit eErr, output int eReads, output bit eHalt);
        int len;
        bit [7:0] b;
        bit [63:0] a;
        eBytes = 80'd0;
        eErr = 1'b0;
        eReads = 0;
        len = 1;
        for (int k = 0; k < len; k++) begin
            a = pc + 64'(k);
            eReads++;
            if (errEn && a == errAt) begin
                eErr = 1'b1;
                break;
            end
            b = memByte(a);
            eBytes[8*k +: 8] = b;
            if (k == 0) len = instrLen(b[7:4]);
        end
        eHalt = eErr || (eBytes[7:4] == 4'h0) || (eBytes[7:4] >= 4'hD);
    endtask

    task automatic doReset();
        rst = 1'b1;
        start = 1'b0;
        start_pc = 64'd0;
        mem_ack = 1'b0;
        mem_error = 1'b0;
        mem_rdata = 8'd0;
        ibytes_ready = 1'b0;
        next_pc_valid = 1'b0;
        next_pc = 64'd0;
        errEn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic doStart(input bit [63:0] pc);
        start = 1'b1;
        start_pc = pc;
        @(negedge clk);
        start = 1'b0;
        start_pc = {$urandom, $urandom};
    endtask

    task automatic doNextPc(input bit [63:0] pc);
        next_pc_valid = 1'b1;
        next_pc = pc;
        @(negedge clk);
        next_pc_valid = 1'b0;
        next_pc = {$urandom, $urandom};
    endtask

    task automatic doAccept();
        ibytes_ready = 1'b1;
        @(negedge clk);
        ibytes_ready = 1'b0;
    endtask

    // Memory responder: acks with probability ackPct until the instruction is presented.
    task automatic fetchOne(input int ackPct);
        readQ.delete();
        timedOut = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            mem_ack = 1'b0;
            mem_error = 1'($urandom);
            mem_rdata = 8'($urandom);
            if (ibytes_valid) begin
                mem_error = 1'b0;
                return;
            end
            if (mem_req && int'($urandom_range(99)) < ackPct) begin
                readQ.push_back(mem_addr);
                mem_ack = 1'b1;
                mem_error = errEn && (mem_addr == errAt);
                mem_rdata = memByte(mem_addr);
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        mem_error = 1'b0;
        timedOut = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        start_pc = 64'h123;
        mem_ack = 1'b1;
        ibytes_ready = 1'b1;
        next_pc_valid = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++; if (mem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        testsRun++; if (mem_addr !== 64'd0) begin testsFailed++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        testsRun++; if (ibytes_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ibytes_valid: got %b expected 0", ibytes_valid); end
        testsRun++; if (cur_pc !== 64'd0) begin testsFailed++; $display("[TB] FAIL reset_cur_pc: got %h expected 0", cur_pc); end
        testsRun++; if ({busy, halted} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_busy_halted: got %b expected 00", {busy, halted}); end
        testsRun++; if ({imem_error, ibytes} !== 81'd0) begin testsFailed++; $display("[TB] FAIL reset_ibytes_err: got %h expected 0", {imem_error, ibytes}); end
        doReset();
    endtask

    task automatic test_nop();
        doReset();
        mem.delete();
        mem[64'h100] = 8'h10;
        doStart(64'h100);
        fetchOne(100);
        testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL nop_timeout: got %b expected 0", timedOut); end
        testsRun++; if (readQ.size() !== 1 || readQ[0] !== 64'h100) begin testsFailed++; $display("[TB] FAIL nop_reads: got %0d reads first %h expected 1 read at 100", readQ.size(), readQ[0]); end
        testsRun++; if ({ibytes_valid, imem_error, cur_pc, ibytes} !== {1'b1, 1'b0, 64'h100, 80'h10}) begin testsFailed++; $display("[TB] FAIL nop_present: got v=%b e=%b pc=%h ib=%h expected v=1 e=0 pc=100 ib=10", ibytes_valid, imem_error, cur_pc, ibytes); end
        doAccept();
        testsRun++; if ({busy, halted, ibytes_valid, mem_req} !== 4'b1000) begin testsFailed++; $display("[TB] FAIL nop_wait_pc: got %b expected 1000", {busy, halted, ibytes_valid, mem_req}); end
    endtask

    task automatic test_irmovq();
        bit [7:0] ir [10];
        bit ok;
        doReset();
        mem.delete();
        ir = '{8'h30, 8'hF2, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int k = 0; k < 10; k++) mem[64'(k)] = ir[k];
        doStart(64'h0);
        fetchOne(60);
        ok = (readQ.size() == 10);
        for (int k = 0; k < readQ.size(); k++) if (readQ[k] !== 64'(k)) ok = 1'b0;
        testsRun++; if (!ok || timedOut) begin testsFailed++; $display("[TB] FAIL irmovq_reads: got %0d reads timeout=%b expected 10 reads at 0..9", readQ.size(), timedOut); end
        testsRun++; if (ibytes !== 80'h0102030405060708F230) begin testsFailed++; $display("[TB] FAIL irmovq_ibytes: got %h expected 0102030405060708f230", ibytes); end
        ibytes_ready = 1'b1;
        next_pc_valid = 1'b1;
        next_pc = 64'h999;
        @(negedge clk);
        ibytes_ready = 1'b0;
        next_pc_valid = 1'b0;
        testsRun++; if ({busy, halted, mem_req, ibytes_valid} !== 4'b1000) begin testsFailed++; $display("[TB] FAIL irmovq_accept_only: got %b expected 1000", {busy, halted, mem_req, ibytes_valid}); end
        repeat (3) @(negedge clk);
        testsRun++; if ({mem_req, cur_pc} !== {1'b0, 64'h0}) begin testsFailed++; $display("[TB] FAIL irmovq_wait_idle: got req=%b pc=%h expected req=0 pc=0", mem_req, cur_pc); end
        doNextPc(64'hA);
        testsRun++; if ({mem_req, mem_addr, cur_pc, ibytes} !== {1'b1, 64'hA, 64'hA, 80'h0}) begin testsFailed++; $display("[TB] FAIL irmovq_resume: got req=%b addr=%h pc=%h ib=%h expected req=1 addr=a pc=a ib=0", mem_req, mem_addr, cur_pc, ibytes); end
    endtask

    task automatic test_jmp();
        bit [79:0] eB;
        bit eErr, eHalt;
        int eReads;
        doReset();
        mem.delete();
        mem[64'h20] = 8'h70;
        for (int k = 1; k < 9; k++) mem[64'h20 + 64'(k)] = 8'($urandom);
        mem[64'h29] = 8'hEE;
        mem[64'h40] = 8'h10;
        modelFetch(64'h20, eB, eErr, eReads, eHalt);
        doStart(64'h20);
        fetchOne(80);
        testsRun++; if (readQ.size() !== 9 || timedOut) begin testsFailed++; $display("[TB] FAIL jmp_read_count: got %0d timeout=%b expected 9", readQ.size(), timedOut); end
        testsRun++; if (ibytes[79:72] !== 8'h00) begin testsFailed++; $display("[TB] FAIL jmp_top_byte: got %h expected 00", ibytes[79:72]); end
        testsRun++; if (ibytes !== eB) begin testsFailed++; $display("[TB] FAIL jmp_ibytes: got %h expected %h", ibytes, eB); end
        doAccept();
        doNextPc(64'h40);
        testsRun++; if ({mem_req, mem_addr} !== {1'b1, 64'h40}) begin testsFailed++; $display("[TB] FAIL jmp_target: got req=%b addr=%h expected req=1 addr=40", mem_req, mem_addr); end
        fetchOne(100);
        start = 1'b1;
        start_pc = 64'h777;
        @(negedge clk);
        start = 1'b0;
        testsRun++; if ({ibytes_valid, cur_pc, ibytes} !== {1'b1, 64'h40, 80'h10}) begin testsFailed++; $display("[TB] FAIL jmp_start_ignored: got v=%b pc=%h ib=%h expected v=1 pc=40 ib=10", ibytes_valid, cur_pc, ibytes); end
    endtask

    task automatic test_error();
        doReset();
        mem.delete();
        mem[64'h300] = 8'h30;
        mem[64'h301] = 8'h11;
        for (int k = 2; k < 10; k++) mem[64'h300 + 64'(k)] = 8'hA0 + 8'(k);
        errEn = 1'b1;
        errAt = 64'h302;
        doStart(64'h300);
        fetchOne(70);
        testsRun++; if (readQ.size() !== 3 || timedOut) begin testsFailed++; $display("[TB] FAIL err_read_count: got %0d timeout=%b expected 3", readQ.size(), timedOut); end
        testsRun++; if ({imem_error, ibytes} !== {1'b1, 80'h1130}) begin testsFailed++; $display("[TB] FAIL err_present: got e=%b ib=%h expected e=1 ib=1130", imem_error, ibytes); end
        doAccept();
        testsRun++; if ({busy, halted} !== 2'b01) begin testsFailed++; $display("[TB] FAIL err_halt: got %b expected 01", {busy, halted}); end
        errEn = 1'b0;
        mem[64'h400] = 8'h20;
        mem[64'h401] = 8'h45;
        doStart(64'h400);
        testsRun++; if ({imem_error, ibytes, cur_pc} !== {1'b0, 80'h0, 64'h400}) begin testsFailed++; $display("[TB] FAIL err_restart_clear: got e=%b ib=%h pc=%h expected e=0 ib=0 pc=400", imem_error, ibytes, cur_pc); end
        fetchOne(100);
        testsRun++; if ({imem_error, ibytes} !== {1'b0, 80'h4520} || readQ.size() !== 2) begin testsFailed++; $display("[TB] FAIL err_restart_fetch: got e=%b ib=%h reads=%0d expected e=0 ib=4520 reads=2", imem_error, ibytes, readQ.size()); end
    endtask

    task automatic test_stall();
        doReset();
        mem.delete();
        mem[64'h500] = 8'h00;
        doStart(64'h500);
        fetchOne(100);
        for (int c = 0; c < 5; c++) begin
            mem_ack = 1'b1;
            mem_rdata = 8'($urandom) | 8'h01;
            next_pc_valid = 1'b1;
            next_pc = {$urandom, $urandom};
            @(negedge clk);
            testsRun++; if ({ibytes_valid, mem_req, imem_error, cur_pc, ibytes} !== {3'b100, 64'h500, 80'h0}) begin testsFailed++; $display("[TB] FAIL stall_hold_%0d: got v=%b req=%b e=%b pc=%h ib=%h expected v=1 req=0 e=0 pc=500 ib=0", c, ibytes_valid, mem_req, imem_error, cur_pc, ibytes); end
        end
        mem_ack = 1'b0;
        next_pc_valid = 1'b0;
        doAccept();
        testsRun++; if ({busy, halted} !== 2'b01) begin testsFailed++; $display("[TB] FAIL stall_halt: got %b expected 01", {busy, halted}); end
        doNextPc(64'h900);
        testsRun++; if ({halted, mem_req} !== 2'b10) begin testsFailed++; $display("[TB] FAIL halt_ignores_next_pc: got %b expected 10", {halted, mem_req}); end
    endtask

    task automatic test_reset_mid();
        doReset();
        mem.delete();
        mem[64'h600] = 8'h30;
        for (int k = 1; k < 10; k++) mem[64'h600 + 64'(k)] = 8'($urandom);
        doStart(64'h600);
        for (int k = 0; k < 4; k++) begin
            mem_ack = 1'b1;
            mem_error = 1'b0;
            mem_rdata = memByte(mem_addr);
            @(negedge clk);
        end
        testsRun++; if ({mem_req, mem_addr} !== {1'b1, 64'h604}) begin testsFailed++; $display("[TB] FAIL rstmid_fifth: got req=%b addr=%h expected req=1 addr=604", mem_req, mem_addr); end
        mem_rdata = memByte(mem_addr);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        testsRun++; if ({mem_req, ibytes_valid, busy, halted, imem_error, mem_addr, cur_pc, ibytes} !== 213'd0) begin testsFailed++; $display("[TB] FAIL rstmid_outputs: got req=%b v=%b busy=%b h=%b e=%b addr=%h pc=%h ib=%h expected all 0", mem_req, ibytes_valid, busy, halted, imem_error, mem_addr, cur_pc, ibytes); end
        repeat (3) begin
            mem_rdata = 8'($urandom);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        testsRun++; if ({mem_req, busy, ibytes} !== 82'd0) begin testsFailed++; $display("[TB] FAIL rstmid_stray_ack: got req=%b busy=%b ib=%h expected 0 0 0", mem_req, busy, ibytes); end
    endtask

    task automatic test_random();
        bit [63:0] pc;
        bit [79:0] eB;
        bit eErr, eHalt, inWait, ok;
        int eReads;
        doReset();
        mem.delete();
        inWait = 1'b0;
        for (int n = 0; n < 40; n++) begin
            pc = (n % 8 == 7) ? 64'hFFFF_FFFF_FFFF_FFFB : {$urandom, $urandom};
            for (int k = 0; k < 10; k++) mem[pc + 64'(k)] = 8'($urandom);
            mem[pc] = {4'($urandom_range(15)), 4'($urandom)};
            errEn = ($urandom_range(7) == 0);
            errAt = pc + 64'($urandom_range(9));
            modelFetch(pc, eB, eErr, eReads, eHalt);
            if (inWait) doNextPc(pc);
            else doStart(pc);
            fetchOne(int'($urandom_range(100, 30)));
            ok = (readQ.size() == eReads) && !timedOut;
            for (int k = 0; k < readQ.size(); k++) if (readQ[k] !== pc + 64'(k)) ok = 1'b0;
            testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL rand_reads_%0d: got %0d reads timeout=%b expected %0d from %h", n, readQ.size(), timedOut, eReads, pc); end
            testsRun++; if ({ibytes, imem_error, cur_pc} !== {eB, eErr, pc}) begin testsFailed++; $display("[TB] FAIL rand_present_%0d: got ib=%h e=%b pc=%h expected ib=%h e=%b pc=%h", n, ibytes, imem_error, cur_pc, eB, eErr, pc); end
            doAccept();
            testsRun++; if ({busy, halted} !== {!eHalt, eHalt}) begin testsFailed++; $display("[TB] FAIL rand_after_accept_%0d: got busy=%b h=%b expected busy=%b h=%b", n, busy, halted, !eHalt, eHalt); end
            inWait = !eHalt;
        end
        errEn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nop();
        test_irmovq();
        test_jmp();
        test_error();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
